// File: rtl/load_store_unit.sv
// Data-memory load/store stage: latches one request, reads the 64-bit doubleword,
// extends loads or read-modify-writes narrow stores, and flags misaligned accesses.
module load_store_unit #(
    parameter int ADDR_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_store,
    input  logic [1:0]        tam,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    input  logic [63:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_we,
    output logic [63:0]       load_data,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    generate
        if (READ_LAT != 1) begin : g_lat_check
            $error("load_store_unit: only READ_LAT == 1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        tam_r;
    logic              uns_r;
    logic              store_r;
    logic              fault_r;
    logic              fault_in;
    logic [2:0]        off;
    logic [63:0]       lane;
    logic [63:0]       ext;
    logic [7:0]        nmask;
    logic [7:0]        bsel;
    logic [63:0]       bitmask;
    logic [63:0]       merged;

    assign off      = addr_r[2:0];
    assign mem_addr = {addr_r[ADDR_W-1:3], 3'b000};

    always_comb begin
        fault_in = 1'b0;
        case (tam)
            2'b00:   fault_in = |addr[2:0];
            2'b01:   fault_in = |addr[1:0];
            2'b10:   fault_in = addr[0];
            default: fault_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // A simultaneous load request is dropped in favour of the store.
                if (start_store)
                    next_state = fault_in ? FIN : ((tam == 2'b00) ? WR : RD);
                else if (start_load)
                    next_state = fault_in ? FIN : RD;
            end
            RD:   next_state = WAIT;
            WAIT: next_state = store_r ? WR : FIN;
            WR: begin
                mem_we     = 1'b1;
                next_state = FIN;
            end
            FIN: begin
                done       = 1'b1;
                misaligned = fault_r;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Lane selection and extension for loads (little-endian byte offset).
    assign lane = mem_rdata >> {off, 3'b000};

    always_comb begin
        ext = lane;
        case (tam_r)
            2'b01:   ext = {{32{~uns_r & lane[31]}}, lane[31:0]};
            2'b10:   ext = {{48{~uns_r & lane[15]}}, lane[15:0]};
            2'b11:   ext = {{56{~uns_r & lane[7]}},  lane[7:0]};
            default: ext = lane;
        endcase
    end

    // Byte-enable mask for the read-modify-write merge of narrow stores.
    always_comb begin
        nmask = 8'hFF;
        case (tam_r)
            2'b01:   nmask = 8'h0F;
            2'b10:   nmask = 8'h03;
            2'b11:   nmask = 8'h01;
            default: nmask = 8'hFF;
        endcase
    end

    assign bsel = nmask << off;

    always_comb begin
        bitmask = '0;
        for (int i = 0; i < 8; i++)
            bitmask[i*8 +: 8] = {8{bsel[i]}};
    end

    // mem_wdata carries the latched store source until the merge overwrites it.
    assign merged = (mem_rdata & ~bitmask) | ((mem_wdata << {off, 3'b000}) & bitmask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r    <= '0;
            tam_r     <= '0;
            uns_r     <= 1'b0;
            store_r   <= 1'b0;
            fault_r   <= 1'b0;
            mem_wdata <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_store || start_load) begin
                        addr_r  <= addr;
                        tam_r   <= tam;
                        uns_r   <= load_unsigned;
                        store_r <= start_store;
                        fault_r <= fault_in;
                        if (start_store)
                            mem_wdata <= store_data;
                    end
                end
                WAIT: begin
                    if (store_r) mem_wdata <= merged;
                    else         load_data <= ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load, start_store;
    logic [1:0]  tam;
    logic        load_unsigned;
    logic [63:0] addr, store_data;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr, mem_wdata, load_data;
    logic        mem_we, busy, done, misaligned;

    load_store_unit #(.ADDR_W(64), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .start_load(start_load), .start_store(start_store),
        .tam(tam), .load_unsigned(load_unsigned),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .load_data(load_data), .busy(busy), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ld;
        logic        mis;
        int          lat;
        int          we_n;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [0:15];
    logic [7:0]  rbytes [0:127];
    logic        init_done = 1'b0;
    int          we_total = 0;
    logic [63:0] last_ld = '0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [63:0] init_val(input int i);
        if (i == 2) return 64'h8877665544332211;
        return {32'(i) * 32'h9E3779B9, (32'(i) * 32'h7F4A7C15) ^ 32'hA5A50F0F};
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[6:3]] <= mem_wdata;
            we_total <= we_total + 1;
        end
        mem_rdata <= mem[mem_addr[6:3]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] t);
        case (t)
            2'b00:   return 8;
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] ref_dw(input int idx);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[b*8 +: 8] = rbytes[idx*8 + b];
        return v;
    endfunction

    function automatic logic [63:0] mdl_load(input logic [63:0] a, input logic [1:0] t, input logic u);
        int n;
        logic [63:0] v;
        n = nbytes(t);
        v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = rbytes[int'(a[6:0]) + i];
        if (!u && v[n*8-1])
            for (int i = n*8; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic issue(input string tag, input logic ld, input logic st, input logic [1:0] t,
                         input logic u, input logic [63:0] a, input logic [63:0] sd, input logic poke);
        exp_t e;
        int   n, lat, we_n;
        logic flt, got, mis_seen;
        n   = nbytes(t);
        flt = (int'(a[2:0]) & (n - 1)) != 0;
        e.mis = flt; e.ld = last_ld; e.we_n = 0;
        if (flt) begin
            e.lat = 1;
        end else if (st) begin
            e.we_n = 1;
            e.lat  = (n == 8) ? 2 : 4;
            for (int i = 0; i < n; i++) rbytes[int'(a[6:0]) + i] = sd[i*8 +: 8];
        end else begin
            e.lat = 3;
            e.ld  = mdl_load(a, t, u);
        end
        last_ld = e.ld;
        sb.push_back(e);

        @(negedge clk);
        start_load = ld; start_store = st; tam = t; load_unsigned = u; addr = a; store_data = sd;
        @(negedge clk);
        // Scramble request inputs so the DUT must rely on its latched copy.
        start_load = 1'b0; start_store = 1'b0; tam = 2'($urandom);
        load_unsigned = 1'($urandom); addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
        got = 1'b0; lat = 0; we_n = 0; mis_seen = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (c == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (mem_we) begin
                we_n++;
                chk({tag, "_waddr"}, mem_addr, {a[63:3], 3'b000});
            end
            if (done) begin
                got = 1'b1; lat = c; mis_seen = misaligned;
            end else begin
                if (poke && c < 3) begin
                    start_store = 1'b1; tam = 2'b00; addr = 64'h48; store_data = '1;
                end else begin
                    start_store = 1'b0;
                end
                @(negedge clk);
            end
        end
        start_store = 1'b0;
        if (!got) chk({tag, "_timeout"}, 64'd0, 64'd1);
        e = sb.pop_front();
        chk({tag, "_lat"},  64'(lat),      64'(e.lat));
        chk({tag, "_mis"},  64'(mis_seen), 64'(e.mis));
        chk({tag, "_we_n"}, 64'(we_n),     64'(e.we_n));
        chk({tag, "_ld"},   load_data,     e.ld);
        if (st && !flt) chk({tag, "_mem"}, mem[a[6:3]], ref_dw(int'(a[6:3])));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] iv;
        int          we_before;
        reset = 1'b1; start_load = 1'b0; start_store = 1'b0; tam = '0;
        load_unsigned = 1'b0; addr = '0; store_data = '0;
        for (int i = 0; i < 16; i++) begin
            iv = init_val(i);
            for (int b = 0; b < 8; b++) rbytes[i*8 + b] = iv[b*8 +: 8];
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mis",  64'(misaligned), 64'd0);
        chk("rst_we",   64'(mem_we), 64'd0);
        chk("rst_ld",   load_data, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wd",   mem_wdata, 64'd0);
        reset = 1'b0;

        issue("ld_b_s", 1, 0, 2'b11, 0, 64'h17, 64'd0, 0);
        chk("ld_b_s_val", load_data, 64'hFFFFFFFFFFFFFF88);
        issue("ld_h_u", 1, 0, 2'b10, 1, 64'h16, 64'd0, 0);
        chk("ld_h_u_val", load_data, 64'h0000000000008877);
        issue("ld_w_s", 1, 0, 2'b01, 0, 64'h14, 64'd0, 0);
        chk("ld_w_s_val", load_data, 64'hFFFFFFFF88776655);
        issue("st_h", 0, 1, 2'b10, 0, 64'h12, 64'h00000000AAAABEEF, 0);
        chk("st_h_val", mem[2], 64'h88776655BEEF2211);
        issue("st_d", 0, 1, 2'b00, 0, 64'h20, 64'h0123456789ABCDEF, 0);
        chk("st_d_val", mem[4], 64'h0123456789ABCDEF);
        issue("mis_ld_w", 1, 0, 2'b01, 0, 64'h22, 64'd0, 0);
        chk("mis_ld_keep", load_data, 64'hFFFFFFFF88776655);
        issue("mis_st_h", 0, 1, 2'b10, 0, 64'h21, 64'h1234, 0);
        chk("mis_st_mem", mem[4], 64'h0123456789ABCDEF);
        issue("poke", 1, 0, 2'b00, 0, 64'h20, 64'd0, 1);
        chk("poke_val", load_data, 64'h0123456789ABCDEF);
        chk("poke_mem", mem[9], ref_dw(9));
        issue("both", 1, 1, 2'b00, 0, 64'h28, 64'hFEEDFACECAFEF00D, 0);
        chk("both_mem", mem[5], 64'hFEEDFACECAFEF00D);
        chk("both_ld", load_data, 64'h0123456789ABCDEF);

        // Reset while a narrow store sits in WAIT.
        we_before = we_total;
        @(negedge clk);
        start_store = 1'b1; tam = 2'b01; addr = 64'h30; store_data = 64'hDEADBEEF; load_unsigned = 1'b0;
        @(negedge clk);
        start_store = 1'b0;
        @(negedge clk);
        chk("rw_busy_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rw_we",   64'(mem_we), 64'd0);
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_done", 64'(done), 64'd0);
        chk("rw_mis",  64'(misaligned), 64'd0);
        chk("rw_ld",   load_data, 64'd0);
        chk("rw_addr", mem_addr, 64'd0);
        chk("rw_wd",   mem_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_ld = '0;
        repeat (3) @(negedge clk);
        chk("rw_no_we", 64'(we_total), 64'(we_before));
        chk("rw_mem", mem[6], ref_dw(6));

        for (int k = 0; k < 24; k++) begin
            logic st, ld;
            st = 1'($urandom);
            ld = !st || 1'($urandom);
            issue($sformatf("rnd%0d", k), ld, st, 2'($urandom), 1'($urandom),
                  64'($urandom_range(0, 127)), {$urandom, $urandom}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
